// File: rtl/cpu_step_ctrl_pkg.sv
// cpu_step_ctrl_pkg: shared debounce state encoding, default timing constants and width helper
package cpu_step_ctrl_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int RUN_DIV_DEF = 8388608;
    typedef enum logic [1:0] {DB_IDLE, DB_PRESS_WAIT, DB_HELD, DB_REL_WAIT} db_state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cpu_step_ctrl_if.sv
// cpu_step_ctrl_if: board keys in, CPU clock-enable and debug outputs
interface cpu_step_ctrl_if;
    logic        key_step_n;
    logic        key_mode_n;
    logic        cpu_ce;
    logic        run_mode;
    logic [15:0] step_count;
    logic        heartbeat;
    modport master (output key_step_n, key_mode_n, input cpu_ce, run_mode, step_count, heartbeat);
    modport slave (input key_step_n, key_mode_n, output cpu_ce, run_mode, step_count, heartbeat);
endinterface

// File: rtl/cpu_step_ctrl_key_debounce.sv
// key_debounce: 2-flop synchronizer plus debounce FSM, one-cycle pulse per accepted press
module key_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic          sync1_q, sync2_q;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // synchronizer idles released; FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // counter defaults to 0 so every state entry and every stable state clears it
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_o = 1'b0;
        case (state_q)
            DB_IDLE:       if (!sync2_q) state_d = DB_PRESS_WAIT;
            DB_PRESS_WAIT: begin
                if (sync2_q) state_d = DB_IDLE;
                else if (cnt_q == LAST) begin
                    state_d = DB_HELD;
                    press_o = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            end
            DB_HELD:       if (sync2_q) state_d = DB_REL_WAIT;
            DB_REL_WAIT: begin
                if (!sync2_q) state_d = DB_HELD;
                else if (cnt_q == LAST) state_d = DB_IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default:       state_d = DB_IDLE;
        endcase
    end
endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: step/run clock-enable generator for a single-clock CPU with debug counters
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int RUN_DIV = RUN_DIV_DEF
) (
    input logic clk,
    input logic rst,
    cpu_step_ctrl_if.slave bus
);
    localparam int DW = cnt_w(RUN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);
    logic          step_p, mode_p;
    logic          run_mode_q, run_mode_d, cpu_ce_q, cpu_ce_d, hb_q, hb_d;
    logic [DW-1:0] div_q, div_d;
    logic [15:0]   step_count_q, step_count_d;
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk(clk), .rst(rst), .key_n_i(bus.key_step_n), .press_o(step_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst(rst), .key_n_i(bus.key_mode_n), .press_o(mode_p)
    );
    // a mode press overrides both the divider terminal and a simultaneous step press
    always_comb begin
        run_mode_d   = run_mode_q ^ mode_p;
        div_d        = (mode_p || !run_mode_q || div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        cpu_ce_d     = !mode_p && (run_mode_q ? div_q == DIV_LAST : step_p);
        step_count_d = step_count_q + {15'd0, cpu_ce_d};
        hb_d         = hb_q ^ cpu_ce_d;
    end
    // registered enable and counters, all updated together with the pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            run_mode_q   <= 1'b0;
            div_q        <= '0;
            cpu_ce_q     <= 1'b0;
            step_count_q <= '0;
            hb_q         <= 1'b0;
        end else begin
            run_mode_q   <= run_mode_d;
            div_q        <= div_d;
            cpu_ce_q     <= cpu_ce_d;
            step_count_q <= step_count_d;
            hb_q         <= hb_d;
        end
    end
    assign bus.cpu_ce     = cpu_ce_q;
    assign bus.run_mode   = run_mode_q;
    assign bus.step_count = step_count_q;
    assign bus.heartbeat  = hb_q;
endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable clk cycles (10 ms at 50 MHz) before a key level is accepted.
REQ-002 Parameter RUN_DIV, default 8388608, clk cycles between cpu_ce pulses in run mode (~6 Hz at 50 MHz).
REQ-003 clk  input  1  sole clock, board 50 MHz; all flops on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_step_n  input  1  raw asynchronous push-button, active-low, one CPU step per accepted press.
REQ-006 key_mode_n  input  1  raw asynchronous push-button, active-low, toggles run/step mode per accepted press.
REQ-007 cpu_ce  output  1  one-clk-wide clock-enable pulse; CPU state (PC, regfile, FSM, BRAM) advances only on cycles where cpu_ce=1.
REQ-008 run_mode  output  1  1 = free-running at RUN_DIV rate, 0 = single-step.
REQ-009 step_count  output  16  number of cpu_ce pulses since reset, for LEDR/HEX debug.
REQ-010 heartbeat  output  1  toggles on every cpu_ce pulse.

Function
REQ-011 Each key SHALL pass a 2-flop synchronizer before any other logic; synchronizer flops reset to 1 (released).
REQ-012 Each debouncer SHALL be a 4-state FSM: IDLE (released), PRESS_WAIT, HELD, REL_WAIT, with a counter cleared on every state entry.
REQ-013 IDLE -> PRESS_WAIT when synced level = 0; otherwise stay.
REQ-014 PRESS_WAIT -> IDLE if synced level = 1; -> HELD when counter = DEBOUNCE_CYCLES-1 with level still 0, emitting a one-cycle press pulse on that transition cycle.
REQ-015 HELD -> REL_WAIT when synced level = 1; no pulse while held, however long.
REQ-016 REL_WAIT -> HELD if synced level = 0; -> IDLE when counter = DEBOUNCE_CYCLES-1 with level still 1; release emits no pulse.
REQ-017 A mode press pulse SHALL toggle run_mode on the following clk edge and clear the run divider to 0.
REQ-018 In run mode, divider SHALL count 0..RUN_DIV-1 and wrap; cpu_ce = 1 for exactly the cycle after the divider holds RUN_DIV-1 (registered output).
REQ-019 In step mode, divider SHALL hold 0; each step press pulse SHALL produce exactly one cpu_ce pulse one clk later.
REQ-020 Step press pulses in run mode SHALL be ignored (no extra cpu_ce, no queuing).
REQ-021 Mode press and divider terminal in the same cycle: mode toggle wins, no cpu_ce generated from that terminal.
REQ-022 Mode press and step press in the same cycle: mode toggle applied, step press ignored.
REQ-023 cpu_ce SHALL never be high on two consecutive cycles (RUN_DIV >= 2 is required; smaller values are a parameter error).
REQ-024 step_count SHALL increment by 1 on each cpu_ce, wrapping 0xFFFF -> 0x0000.
REQ-025 Counter widths SHALL be $clog2 of the respective parameter, no truncation at default values.

Reset
REQ-026 While rst=1: cpu_ce=0, run_mode=0, step_count=0x0000, heartbeat=0, divider=0, both debouncers IDLE with counters 0, synchronizers 1.
REQ-027 Reset asserted mid-debounce or mid-divide SHALL abandon the operation with no pulse on any output; first possible cpu_ce is DEBOUNCE_CYCLES+3 cycles after rst falls (step press held throughout).
REQ-028 A key held low through reset release SHALL be treated as a fresh press (IDLE -> PRESS_WAIT), yielding one pulse after debounce.

Structure
REQ-029 Debounce FSM state encoding and default DEBOUNCE_CYCLES/RUN_DIV constants SHALL live in the shared cpu package.
REQ-030 Synchronizer + debounce FSM SHALL be one sub-module, key_debounce, instantiated twice; divider, mode toggle, and counters stay in cpu_step_ctrl.
REQ-031 Downstream CPU logic SHALL keep running on clk and gate state updates with cpu_ce; no derived clocks.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=5)
REQ-032 Reset, step key low 20 cycles then high -> exactly one cpu_ce, step_count=1, heartbeat=1, run_mode=0.
REQ-033 Step key glitch low 3 cycles then high, repeated 5 times -> no cpu_ce, step_count=0.
REQ-034 Mode press -> run_mode=1; over 50 cycles cpu_ce pulses every 5 cycles, step_count=10 (+/-1 at window edge), a step press during run adds nothing.
REQ-035 Mode press timed so its pulse coincides with divider=4 -> run_mode=0, no cpu_ce that cycle, divider reads 0.
REQ-036 Run mode, preload via 65536 pulses -> step_count wraps to 0x0000, heartbeat back to initial value.
REQ-037 Assert rst during PRESS_WAIT and during run -> all outputs at reset values next cycle, no pulse emitted, run_mode=0.
